// File: rtl/floo_rob_slot_tracker_pkg.sv
// Shared types and defaults for the ROB slot tracker.
// Build option: FLOO_ROB_SLOT_TRACKER_ERR_EN enables the sticky error flag.
package floo_rob_slot_tracker_pkg;

  localparam int unsigned RobSizeDef = 64;
  localparam int unsigned MaxLenDef  = 3;
  localparam int unsigned IdxWDef    = $clog2(RobSizeDef);

  typedef logic [IdxWDef-1:0] rob_idx_t;

  // Slot i lies in the run [tail, tail+n) taken modulo a power-of-2 size.
  function automatic logic in_run(
    int unsigned i,
    int unsigned tail,
    int unsigned n,
    int unsigned size
  );
    return ((i - tail) & (size - 1)) < n;
  endfunction

endpackage

// File: rtl/floo_rob_slot_tracker_if.sv
// Alloc / fill / pop channel bundle of the ROB slot tracker.
// Build option: FLOO_ROB_SLOT_TRACKER_ERR_EN (no effect on this file).
interface floo_rob_slot_tracker_if #(
  parameter int unsigned IdxW = 6
);

  logic            alloc_valid_i;
  logic [IdxW-1:0] alloc_len_i;
  logic            alloc_ready_o;
  logic [IdxW-1:0] alloc_idx_o;
  logic            fill_valid_i;
  logic [IdxW-1:0] fill_idx_i;
  logic            pop_valid_o;
  logic [IdxW-1:0] pop_idx_o;
  logic            pop_ready_i;

  modport slave (
    input  alloc_valid_i,
    input  alloc_len_i,
    output alloc_ready_o,
    output alloc_idx_o,
    input  fill_valid_i,
    input  fill_idx_i,
    output pop_valid_o,
    output pop_idx_o,
    input  pop_ready_i
  );

  modport master (
    output alloc_valid_i,
    output alloc_len_i,
    input  alloc_ready_o,
    input  alloc_idx_o,
    output fill_valid_i,
    output fill_idx_i,
    input  pop_valid_o,
    input  pop_idx_o,
    output pop_ready_i
  );

endinterface

// File: rtl/floo_rob_slot_tracker.sv
// ROB slot allocator with out-of-order fill and in-order release.
// Build option: FLOO_ROB_SLOT_TRACKER_ERR_EN builds the sticky err_o logic.
module floo_rob_slot_tracker
  import floo_rob_slot_tracker_pkg::*;
#(
  parameter  int unsigned RobSize = RobSizeDef,
  parameter  int unsigned MaxLen  = MaxLenDef,
  localparam int unsigned IdxW    = $clog2(RobSize)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  floo_rob_slot_tracker_if.slave  bus,
  output logic [IdxW:0]           usage_o,
  output logic                    err_o
);

  localparam logic [IdxW:0] Size = (IdxW+1)'(RobSize);

  logic [IdxW-1:0]    head_q, tail_q;
  logic [IdxW:0]      count_q, count_d;
  logic [RobSize-1:0] alloc_q, alloc_d;
  logic [RobSize-1:0] filled_q, filled_d;

  logic [IdxW:0] n;
  logic          len_ok;
  logic          alloc_hs;
  logic          pop_hs;
  logic          fill_ok;

  assign n      = {1'b0, bus.alloc_len_i} + (IdxW+1)'(1);
  assign len_ok = 32'(bus.alloc_len_i) <= MaxLen;

  // Slots freed by a pop this cycle are deliberately not counted as free.
  assign bus.alloc_ready_o = len_ok && ((Size - count_q) >= n);
  assign bus.alloc_idx_o   = tail_q;
  assign alloc_hs          = bus.alloc_valid_i && bus.alloc_ready_o;

  assign bus.pop_valid_o = filled_q[head_q];
  assign bus.pop_idx_o   = head_q;
  assign pop_hs          = bus.pop_valid_o && bus.pop_ready_i;

  assign fill_ok = bus.fill_valid_i
                && alloc_q[bus.fill_idx_i]
                && !filled_q[bus.fill_idx_i];

  assign usage_o = count_q;

  always_comb begin
    alloc_d  = alloc_q;
    filled_d = filled_q;
    count_d  = count_q;
    if (alloc_hs) begin
      for (int unsigned i = 0; i < RobSize; i++) begin
        if (in_run(i, 32'(tail_q), 32'(n), RobSize)) begin
          alloc_d[i] = 1'b1;
        end
      end
      count_d = count_d + n;
    end
    if (fill_ok) begin
      filled_d[bus.fill_idx_i] = 1'b1;
    end
    if (pop_hs) begin
      alloc_d[head_q]  = 1'b0;
      filled_d[head_q] = 1'b0;
      count_d          = count_d - (IdxW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      alloc_q  <= '0;
      filled_q <= '0;
    end else begin
      alloc_q  <= alloc_d;
      filled_q <= filled_d;
      count_q  <= count_d;
      if (alloc_hs) begin
        tail_q <= tail_q + n[IdxW-1:0];
      end
      if (pop_hs) begin
        head_q <= head_q + IdxW'(1);
      end
    end
  end

`ifdef FLOO_ROB_SLOT_TRACKER_ERR_EN
  logic err_q;
  logic err_set;

  assign err_set = (bus.fill_valid_i
                 && (!alloc_q[bus.fill_idx_i] || filled_q[bus.fill_idx_i]))
                || (alloc_hs && !len_ok);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_floo_rob_slot_tracker.sv
// Randomized scoreboard bench for floo_rob_slot_tracker.
// Build option: FLOO_ROB_SLOT_TRACKER_ERR_EN switches the err_o expectation.
module tb_floo_rob_slot_tracker;

  localparam int RobSize = 64;
  localparam int MaxLen  = 3;
  localparam int IdxW    = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IdxW:0] usage;
  logic          err;

  floo_rob_slot_tracker_if #(.IdxW(IdxW)) bus ();

  floo_rob_slot_tracker #(
    .RobSize (RobSize),
    .MaxLen  (MaxLen)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bus     (bus),
    .usage_o (usage),
    .err_o   (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: allocation-order list of outstanding slots.
  int ord[$];
  int exp_q[$];
  bit mf[RobSize];
  bit ma[RobSize];
  int tail = 0;
  bit merr = 1'b0;
  bit drain_mode = 1'b0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    ord.delete();
    exp_q.delete();
    for (int i = 0; i < RobSize; i++) begin
      mf[i] = 1'b0;
      ma[i] = 1'b0;
    end
    tail = 0;
    merr = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.alloc_valid_i = 1'b0;
    bus.alloc_len_i   = '0;
    bus.fill_valid_i  = 1'b0;
    bus.fill_idx_i    = '0;
    bus.pop_ready_i   = 1'b0;
  endtask

  task automatic check_state();
    bit pv;
    pv = (ord.size() > 0) && mf[ord[0]];
    check("usage", 32'(usage), 32'(ord.size()));
    check("pop_valid", 32'(bus.pop_valid_o), 32'(pv));
    if (pv) check("pop_idx", 32'(bus.pop_idx_o), 32'(ord[0]));
`ifdef FLOO_ROB_SLOT_TRACKER_ERR_EN
    check("err", 32'(err), 32'(merr));
`else
    check("err", 32'(err), 32'd0);
`endif
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    clear_model();
    check("rst_usage", 32'(usage), 32'd0);
    check("rst_pop_valid", 32'(bus.pop_valid_o), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_cycle(int pop_pct, bit allow_alloc, bit illegal);
    int  len;
    int  n;
    int  k;
    bit  av;
    bit  fv;
    int  fidx;
    bit  pr;
    bit  rdy;
    bit  pv;
    @(posedge clk);
    #1;
    check_state();
    av  = allow_alloc && ($urandom % 2 == 0);
    len = ($urandom % 8 == 0) ? MaxLen + 1 : int'($urandom_range(0, MaxLen));
    fv  = 1'b0;
    fidx = 0;
    if (drain_mode) begin
      foreach (ord[j]) begin
        if (!fv && !mf[ord[j]]) begin
          fv = 1'b1;
          fidx = ord[j];
        end
      end
    end else if (ord.size() > 0 && ($urandom % 4 != 0)) begin
      k = int'($urandom_range(0, ord.size() - 1));
      if (!mf[ord[k]]) begin
        fv = 1'b1;
        fidx = ord[k];
      end
    end
    if (illegal && ($urandom % 20 == 0)) begin
      fv = 1'b1;
      fidx = int'($urandom % RobSize);
    end
    pr = int'($urandom % 100) < pop_pct;
    bus.alloc_valid_i = av;
    bus.alloc_len_i   = IdxW'(len);
    bus.fill_valid_i  = fv;
    bus.fill_idx_i    = IdxW'(fidx);
    bus.pop_ready_i   = pr;
    #1;
    n   = len + 1;
    rdy = (len <= MaxLen) && (RobSize - ord.size() >= n);
    check("alloc_ready", 32'(bus.alloc_ready_o), 32'(rdy));
    check("alloc_idx", 32'(bus.alloc_idx_o), 32'(tail));
    // Advance the model over the coming edge.
    pv = (ord.size() > 0) && mf[ord[0]];
    if (fv) begin
      if (ma[fidx] && !mf[fidx]) mf[fidx] = 1'b1;
      else merr = 1'b1;
    end
    if (pv && pr) begin
      k = ord.pop_front();
      ma[k] = 1'b0;
      mf[k] = 1'b0;
    end
    if (av && rdy) begin
      for (int j = 0; j < n; j++) begin
        k = (tail + j) % RobSize;
        ma[k] = 1'b1;
        ord.push_back(k);
        exp_q.push_back(k);
      end
      tail = (tail + n) % RobSize;
    end
  endtask

  // Monitor: every released slot must match allocation order.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.pop_valid_o && bus.pop_ready_i) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 32'(bus.pop_idx_o), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("pop_order", 32'(bus.pop_idx_o), 32'(e));
        end
      end
    end
  end

  initial begin
    idle_inputs();
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check("init_usage", 32'(usage), 32'd0);
    check("init_pop_valid", 32'(bus.pop_valid_o), 32'd0);
    check("init_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("init_ready", 32'(bus.alloc_ready_o), 32'd1);
    check("init_idx", 32'(bus.alloc_idx_o), 32'd0);
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      case (c / 500)
        0:       do_cycle(90, 1'b1, 1'b0);
        1:       do_cycle(10, 1'b1, 1'b0);
        2:       do_cycle(50, 1'b1, 1'b0);
        3:       do_cycle(5,  1'b1, 1'b0);
        4:       do_cycle(60, 1'b1, 1'b0);
        default: do_cycle(40, 1'b1, 1'b1);
      endcase
    end
    drain_mode = 1'b1;
    for (int c = 0; c < 400; c++) do_cycle(100, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("drain_usage", 32'(usage), 32'd0);
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    idle_inputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
